dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the core's data memory interface. It is the slave end of the o_mem_* / i_mem_rd_data bus.
- Adds a request/ready handshake with a programmable wait-state count, so the core sees a multi-cycle memory instead of a zero-latency array.
- Holds a word-addressed RAM and flags misaligned or out-of-range accesses.
- Sits beside the core in the brimstone top level, in place of the combinational data memory.

Parameters:
- DATA_WIDTH_P, 32, data word width; fixed at 32 (byte offset is addr[1:0]).
- DATA_ADDR_WIDTH_P, 32, byte address width.
- DEPTH_P, 256, number of words in the RAM; power of two.
- WAIT_CYCLES_P, 2, wait states inserted between accept and response; range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- i_mem_req  input  1  request valid from core
- i_mem_wr_en  input  1  1 = write, 0 = read; sampled with i_mem_req
- i_mem_addr  input  DATA_ADDR_WIDTH_P  byte address
- i_mem_wr_data  input  DATA_WIDTH_P  write data
- o_mem_busy  output  1  high while a request is outstanding (WAIT or RESP state)
- o_mem_ready  output  1  one-cycle completion pulse
- o_mem_rd_data  output  DATA_WIDTH_P  read data; valid only while o_mem_ready=1
- o_mem_err  output  1  error flag; valid only while o_mem_ready=1

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous and active-low: sampled on the rising edge of clk while 0.
  - Reset values: state=IDLE, o_mem_busy=0, o_mem_ready=0, o_mem_rd_data=0, o_mem_err=0, wait counter=0.
  - RAM contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - If i_mem_req=1, accept the request: capture wr_en, addr and wr_data into registers.
  - Load the wait counter with WAIT_CYCLES_P.
  - Next state: WAIT if WAIT_CYCLES_P>0, else RESP.
- WAIT:
  - Counter decrements each cycle; move to RESP on the cycle the counter reaches 1.
  - WAIT lasts exactly WAIT_CYCLES_P cycles.
- RESP:
  - o_mem_ready=1 for exactly one cycle; next state is always IDLE.
  - One idle bubble is mandatory: a new request is accepted no earlier than the cycle after RESP.
- Latency: with the accept edge as cycle 0, o_mem_ready is high in cycle 1+WAIT_CYCLES_P.
- Output timing: o_mem_ready, o_mem_rd_data and o_mem_err are registered and change only on clock edges.
- i_mem_req is ignored while busy. The captured request cannot be altered by input changes after accept.
- Error check on the captured address:
  - err = (addr[1:0] != 0) OR (addr[DATA_ADDR_WIDTH_P-1:2] >= DEPTH_P).
  - On error: no RAM write, o_mem_rd_data=0, o_mem_err=1 with ready.
- Write (no error):
  - RAM[addr>>2] is written on the RESP-entry edge, so the new data is visible to any later read.
  - o_mem_rd_data=0 during the write response.
- Read (no error): o_mem_rd_data = RAM[addr>>2] sampled on the RESP-entry edge.
- Outside RESP: o_mem_rd_data=0 and o_mem_err=0.
- Reset mid-operation (reset=0 in WAIT or RESP):
  - Return to IDLE and drop the pending request; a pending write is not committed.
  - o_mem_ready is not pulsed.
- Word index uses addr[log2(DEPTH_P)+1:2] after the range check passes.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds three output ports, each 16 bits wide:
  - o_rd_count: successful reads.
  - o_wr_count: successful writes.
  - o_err_count: errored accesses.
- Counter rules when defined:
  - Each counter increments on the RESP cycle of a matching access.
  - Counters saturate at 16'hFFFF.
  - Counters are cleared by reset.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then write: hold reset=0 for 3 cycles, release; write 0xDEADBEEF to addr 0x10 with WAIT_CYCLES_P=2 -> o_mem_ready high exactly in cycle 3 after accept, o_mem_err=0.
- Read back: read addr 0x10 -> o_mem_ready pulse in cycle 3 with o_mem_rd_data=0xDEADBEEF; o_mem_busy high in cycles 1-3.
- Misaligned and out-of-range accesses:
  - Write 0x12345678 to addr 0x11 -> ready with o_mem_err=1; a subsequent read of 0x10 still returns 0xDEADBEEF.
  - Read addr 0x400 with DEPTH_P=256 -> o_mem_err=1, o_mem_rd_data=0.
- Zero wait states and busy-time requests:
  - With WAIT_CYCLES_P=0, issue back-to-back requests with i_mem_req held high -> ready in cycle 1 after each accept, then one idle bubble before the next accept.
  - i_mem_req toggling while busy -> no extra accept.
- Reset mid-write: reset=0 while in WAIT during a write of 0xCAFEF00D to addr 0x20 -> no ready pulse; after release, a read of 0x20 returns the prior contents (previously written 0x0).
- DMEM_STATS_EN defined: 3 reads, 2 writes, 1 error -> o_rd_count=3, o_wr_count=2, o_err_count=1; reset clears all three to 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word RAM slave with misalign/range error flag.
// Defining DMEM_STATS_EN adds saturating read/write/error access counters.
module dmem_responder #(
  parameter int DATA_WIDTH_P = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int DEPTH_P = 256,
  parameter int WAIT_CYCLES_P = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_mem_req,
  input  logic                         i_mem_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
  output logic                         o_mem_busy,
  output logic                         o_mem_ready,
  output logic [DATA_WIDTH_P-1:0]      o_mem_rd_data,
  output logic                         o_mem_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]                  o_rd_count,
  output logic [15:0]                  o_wr_count,
  output logic [15:0]                  o_err_count
`endif
);
  localparam int IW = $clog2(DEPTH_P);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic we_q, we_c, err_c, accept, go_resp;
  logic [DATA_ADDR_WIDTH_P-1:0] addr_q, addr_c;
  logic [DATA_WIDTH_P-1:0] wdata_q, wdata_c;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];
  assign accept  = state == S_IDLE && i_mem_req;
  assign go_resp = reset && state_nx == S_RESP;
  // With zero wait states RESP is entered on the accept edge, before the capture registers load
  assign we_c    = state == S_IDLE ? i_mem_wr_en : we_q;
  assign addr_c  = state == S_IDLE ? i_mem_addr : addr_q;
  assign wdata_c = state == S_IDLE ? i_mem_wr_data : wdata_q;
  assign err_c   = |addr_c[1:0] || addr_c[DATA_ADDR_WIDTH_P-1:2] >= (DATA_ADDR_WIDTH_P-2)'(DEPTH_P);
  assign idx     = addr_c[IW+1:2];
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= accept ? 4'(WAIT_CYCLES_P) : state == S_WAIT ? cnt - 4'd1 : cnt;
    end
  always_comb
    state_nx = state == S_IDLE ? (i_mem_req ? (WAIT_CYCLES_P > 0 ? S_WAIT : S_RESP) : S_IDLE)
             : state == S_WAIT ? (cnt == 4'd1 ? S_RESP : S_WAIT)
             : S_IDLE;
  always_comb
    o_mem_busy = state != S_IDLE;
  always_ff @(posedge clk)
    if (accept) begin
      we_q    <= i_mem_wr_en;
      addr_q  <= i_mem_addr;
      wdata_q <= i_mem_wr_data;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      o_mem_ready   <= 1'b0;
      o_mem_err     <= 1'b0;
      o_mem_rd_data <= '0;
    end else begin
      o_mem_ready   <= go_resp;
      o_mem_err     <= go_resp && err_c;
      o_mem_rd_data <= go_resp && !err_c && !we_c ? mem[idx] : '0;
    end
  always_ff @(posedge clk)
    if (go_resp && !err_c && we_c) mem[idx] <= wdata_c;
`ifdef DMEM_STATS_EN
  always_ff @(posedge clk)
    if (!reset) begin
      o_rd_count  <= '0;
      o_wr_count  <= '0;
      o_err_count <= '0;
    end else begin
      o_rd_count  <= o_rd_count + 16'(o_mem_ready && !o_mem_err && !we_q && ~&o_rd_count);
      o_wr_count  <= o_wr_count + 16'(o_mem_ready && !o_mem_err && we_q && ~&o_wr_count);
      o_err_count <= o_err_count + 16'(o_mem_ready && o_mem_err && ~&o_err_count);
    end
`endif
endmodule
